timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//  Memory-mapped down-counting timer that sits on the device side of the CPU/device address bridge as DEV0.
//  The bridge supplies the address, write data and write enable; this block returns read data and an interrupt request.
//  IRQ feeds the CP0 external interrupt input.
// PARAMETERS
//  PRESCALE_DIV  4  count-enable divisor; used only when TC_PRESCALE_EN is defined; legal range 2..256.
// PORTS
//  clk    input   1   system clock, rising edge
//  reset  input   1   asynchronous, active-high; clears all state
//  Addr   input   2   word offset from the bridge: DEV_Addr[3:2]
//  WE     input   1   write enable, the bridge's WeDEV0
//  Din    input  32   write data from the bridge
//  Dout   output 32   read data to the bridge's DEV0_RD; combinational from Addr
//  IRQ    output  1   interrupt request, level
// BEHAVIOUR
//  One clock (clk). Asynchronous active-high reset (reset). Every register and the FSM clear to 0/IDLE immediately on reset.
//  Reset value of every output: Dout=0 for all addresses; IRQ=0.
//  Register map:
//   Addr 0 CTRL   R/W  [0]=EN, [2:1]=MODE, [3]=IM; bits [31:4] read 0 and ignore writes.
//   Addr 1 PRESET R/W  full 32 bits.
//   Addr 2 COUNT  R only; writes are ignored.
//   Addr 3 reserved; reads 0, writes ignored.
//  MODE 2'b00 = one-shot. MODE 2'b01 = auto-reload. MODE 2'b1x behaves as one-shot.
//  IRQ = irq_flag & CTRL.IM, driven combinationally from registers.
//  FSM states: IDLE, LOAD, CNT, INT.
//   IDLE: EN=1 -> LOAD.
//   LOAD: COUNT<=PRESET -> CNT.
//   CNT:
//    - EN=0 -> IDLE; COUNT holds.
//    - else if COUNT<=1: COUNT<=0, irq_flag<=1 -> INT.
//    - else COUNT<=COUNT-1.
//   INT, one-shot: EN<=0 -> IDLE. irq_flag holds until software writes CTRL or PRESET.
//   INT, auto-reload: irq_flag<=0; EN=1 -> LOAD, EN=0 -> IDLE.
//  Latency, PRESET=N>=1, write of EN=1 at edge E0:
//   - LOAD at E1; COUNT=N at E2.
//   - COUNT=0 and irq_flag=1 at edge E(N+2).
//   - Auto-reload repeats the IRQ pulse every N+2 cycles; each pulse is 1 cycle wide.
//  PRESET=0 behaves as PRESET=1 (expiry after one CNT cycle).
//  Write to PRESET during CNT: no effect on COUNT until the next LOAD; it still clears irq_flag.
//  Simultaneous events: a CPU write to CTRL on the INT edge wins over the FSM's EN<=0; the written EN value is kept.
//  Reset asserted mid-count: COUNT=0, CTRL=0, PRESET=0, FSM=IDLE; IRQ drops asynchronously.
//  COUNT never wraps below 0; arithmetic is unsigned 32-bit.
// CONFIGURATION
//  TC_PRESCALE_EN defined:
//   - An 8-bit prescaler cleared in LOAD gates decrement and expiry in CNT.
//   - CNT acts only on cycles where the prescaler equals PRESCALE_DIV-1; the prescaler wraps to 0 at that point.
//   - Expiry latency becomes 2+N*PRESCALE_DIV edges.
//   - EN=0 in CNT still exits on the next edge regardless of the prescaler.
//  TC_PRESCALE_EN undefined: no prescaler logic; CNT acts every cycle; PRESCALE_DIV ignored.
// TESTING
//  1. Hold reset 3 cycles mid-operation -> all reads 0, IRQ=0, state IDLE; release -> no activity until EN is written.
//  2. One-shot: PRESET=5, CTRL=4'b1001 (IM=1, mode 0, EN=1)
//     -> COUNT reads 5,4,3,2,1,0; IRQ rises 7 edges after the CTRL write; CTRL reads 4'b1000.
//     -> IRQ stays high until a write CTRL=0, after which IRQ=0 next cycle.
//  3. Auto-reload: PRESET=3, CTRL=4'b1011 -> IRQ 1-cycle pulses every 5 cycles for 4 periods.
//     -> Write CTRL=4'b1010 -> no further pulses; COUNT holds its value.
//  4. Mask: PRESET=2, CTRL=4'b0001 -> COUNT reaches 0 and IRQ stays 0.
//     -> Write CTRL=4'b1000 (IM=1, EN=0): irq_flag is cleared by the write, so IRQ stays 0.
//  5. Boundaries:
//     - PRESET=0, one-shot -> IRQ 3 edges after the enable.
//     - Write COUNT address with 0x1234 -> COUNT unchanged.
//     - Read Addr 3 -> 0.
//     - Write CTRL=4'b1001 on the INT edge -> EN remains 1 and the timer restarts.
//  6. TC_PRESCALE_EN build, PRESCALE_DIV=4, PRESET=2, one-shot -> IRQ 10 edges after the enable; COUNT steps every 4 cycles.

Source files
------------

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module   : timer_counter
//  Purpose  : Memory-mapped down-counting timer (DEV0) with level interrupt.
//             Optional prescaler enabled by defining TC_PRESCALE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module timer_counter #(
    parameter int unsigned PRESCALE_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] c_MODE_AUTO   = 2'b01;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        w_tick;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic        w_auto;

    assign w_wr_ctrl   = WE && (Addr == c_ADDR_CTRL);
    assign w_wr_preset = WE && (Addr == c_ADDR_PRESET);
    assign w_en        = ctrl_q[0];
    assign w_auto      = (ctrl_q[2:1] == c_MODE_AUTO);

`ifdef TC_PRESCALE_EN
    localparam logic [7:0] c_PRESC_TOP = 8'(PRESCALE_DIV - 1);

    logic [7:0] presc_q, presc_d;

    // CNT only decrements/expires on the cycle the prescaler hits its top value
    assign w_tick = (presc_q == c_PRESC_TOP);

    always_comb begin
        presc_d = presc_q;
        if (state_q == LOAD) begin
            presc_d = 8'd0;
        end else if ((state_q == CNT) && w_en) begin
            presc_d = w_tick ? 8'd0 : presc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 8'd0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        // Software acknowledge: any CTRL or PRESET write clears the pending flag
        if (w_wr_ctrl) begin
            ctrl_d     = Din[3:0];
            irq_flag_d = 1'b0;
        end
        if (w_wr_preset) begin
            preset_d   = Din;
            irq_flag_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (w_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!w_en) begin
                    state_d = IDLE;
                end else if (w_tick) begin
                    if (count_q <= 32'd1) begin
                        count_d    = 32'd0;
                        irq_flag_d = 1'b1;
                        state_d    = INT;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
            end
            INT: begin
                if (w_auto) begin
                    irq_flag_d = 1'b0;
                    state_d    = w_en ? LOAD : IDLE;
                end else begin
                    // A simultaneous CTRL write keeps the software-written EN
                    if (!w_wr_ctrl) begin
                        ctrl_d[0] = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr)
            c_ADDR_CTRL:   Dout = {28'd0, ctrl_q};
            c_ADDR_PRESET: Dout = preset_q;
            c_ADDR_COUNT:  Dout = count_q;
            default:       Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q[3];

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// Directed self-checking bench for timer_counter; expected values are hand-derived
// from edge counts relative to the enabling CTRL write.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_vec = 0;
    int n_err = 0;

    timer_counter #(
        .PRESCALE_DIV(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, Dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    // Bus write: takes effect on the next rising edge, returns 1ns after it
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;
        step(3);
        chk_rd("rst_ctrl",   2'd0, 32'd0);
        chk_rd("rst_preset", 2'd1, 32'd0);
        chk_rd("rst_count",  2'd2, 32'd0);
        chk_irq("rst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b0;

`ifdef TC_PRESCALE_EN
        // Prescaled one-shot: PRESET=2, DIV=4 -> expiry at E10
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        step(2);
        chk_rd("ps_count_e2", 2'd2, 32'd2);
        step(3);
        chk_rd("ps_count_e5", 2'd2, 32'd2);
        step(1);
        chk_rd("ps_count_e6", 2'd2, 32'd1);
        step(3);
        chk_rd("ps_count_e9", 2'd2, 32'd1);
        chk_irq("ps_irq_e9", 1'b0);
        step(1);
        chk_rd("ps_count_e10", 2'd2, 32'd0);
        chk_irq("ps_irq_e10", 1'b1);
`else
        // One-shot, PRESET=5: COUNT=5 at E2 ... 0 with IRQ at E7
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step(2);
        for (int k = 5; k >= 0; k--) begin
            chk_rd("os_count", 2'd2, 32'(k));
            chk_irq("os_irq", (k == 0));
            step(1);
        end
        chk_rd("os_ctrl_after", 2'd0, 32'h8);
        chk_irq("os_irq_e8", 1'b1);
        step(3);
        chk_irq("os_irq_hold", 1'b1);
        chk_rd("os_count_hold", 2'd2, 32'd0);
        wr(2'd0, 32'h0);
        chk_irq("os_irq_ack", 1'b0);

        // Auto-reload, PRESET=3: 1-cycle pulses at E5, E10, E15, E20
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int t = 1; t <= 20; t++) begin
            step(1);
            chk_irq("ar_irq", (t % 5) == 0);
        end
        step(3);
        chk_rd("ar_count_e23", 2'd2, 32'd2);
        wr(2'd0, 32'hA);
        chk_rd("ar_count_e24", 2'd2, 32'd1);
        for (int t = 0; t < 6; t++) begin
            step(1);
            chk_irq("ar_stop_irq", 1'b0);
            chk_rd("ar_stop_count", 2'd2, 32'd1);
        end

        // Masked one-shot, PRESET=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        step(6);
        chk_rd("mask_count", 2'd2, 32'd0);
        chk_irq("mask_irq", 1'b0);
        chk_rd("mask_ctrl", 2'd0, 32'd0);
        wr(2'd0, 32'h8);
        chk_irq("mask_ack_irq", 1'b0);
        step(2);
        chk_irq("mask_ack_irq2", 1'b0);

        // PRESET=0 one-shot: IRQ at E3; CTRL write on the INT edge E4 restarts
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(2);
        chk_irq("p0_irq_e2", 1'b0);
        step(1);
        chk_irq("p0_irq_e3", 1'b1);
        wr(2'd0, 32'h9);
        chk_rd("int_wr_ctrl", 2'd0, 32'h9);
        chk_irq("int_wr_irq", 1'b0);
        step(2);
        chk_irq("restart_irq_e6", 1'b0);
        step(1);
        chk_irq("restart_irq_e7", 1'b1);

        // Read-only COUNT, PRESET write mid-count, reserved address
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd16);
        wr(2'd0, 32'h1);
        wr(2'd2, 32'h1234);
        step(3);
        chk_rd("ro_count_e4", 2'd2, 32'd14);
        wr(2'd1, 32'd100);
        chk_rd("midcnt_count", 2'd2, 32'd13);
        chk_rd("midcnt_preset", 2'd1, 32'd100);
        wr(2'd3, 32'hFFFF_FFFF);
        chk_rd("rsvd_read", 2'd3, 32'd0);
        chk_rd("rsvd_count", 2'd2, 32'd12);

        // Asynchronous reset while IRQ is asserted
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        step(3);
        chk_irq("pre_rst_irq", 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_irq("async_rst_irq", 1'b0);
        step(3);
        chk_rd("mid_rst_ctrl",   2'd0, 32'd0);
        chk_rd("mid_rst_preset", 2'd1, 32'd0);
        chk_rd("mid_rst_count",  2'd2, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(5);
        chk_rd("post_rst_count", 2'd2, 32'd0);
        chk_rd("post_rst_ctrl",  2'd0, 32'd0);
        chk_irq("post_rst_irq", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
